// File: rtl/mtimer_if.sv
// Peripheral-bus port bundle for the machine timer: address, write data,
// strobes and registered-address read data.
interface mtimer_if;
  logic [4:0]  addr;
  logic [31:0] data_in;
  logic        write_en;
  logic        read_en;
  logic [31:0] data_out;

  modport master (output addr, data_in, write_en, read_en, input data_out);
  modport slave  (input addr, data_in, write_en, read_en, output data_out);
endinterface

// File: rtl/mtimer.sv
// RISC-V machine timer: prescaled 64-bit mtime, mtimecmp compare, and a
// registered level-sensitive interrupt request for mip.MTIP.
module mtimer #(
  parameter int          PRESCALE_W = 8,
  parameter logic [63:0] CMP_RESET  = 64'hFFFF_FFFF_FFFF_FFFF
) (
  input  logic   i_clk,
  input  logic   i_reset,
  mtimer_if.slave bus,
  output logic   o_intr_timer
);

  localparam logic [2:0] A_MTIME_LO = 3'd0;
  localparam logic [2:0] A_MTIME_HI = 3'd1;
  localparam logic [2:0] A_CMP_LO   = 3'd2;
  localparam logic [2:0] A_CMP_HI   = 3'd3;
  localparam logic [2:0] A_CTRL     = 3'd4;
  localparam logic [2:0] A_STATUS   = 3'd5;

  logic [63:0]           r_mtime;
  logic [63:0]           r_mtimecmp;
  logic                  r_en;
  logic [PRESCALE_W-1:0] r_div;
  logic [PRESCALE_W-1:0] r_cnt;
  logic [31:0]           r_snap;
  logic [2:0]            r_addr_q;
  logic                  r_intr;

  logic [2:0]  w_sel;
  logic        w_wr_lo, w_wr_hi, w_wr_cmp_lo, w_wr_cmp_hi, w_wr_ctrl;
  logic        w_tick;
  logic        w_match;
  logic [31:0] w_ctrl;
  logic        w_unused;

  // Byte-lane bits carry no meaning for word registers.
  assign w_unused = &{1'b0, bus.addr[1:0]};

  assign w_sel       = bus.addr[4:2];
  assign w_wr_lo     = bus.write_en && (w_sel == A_MTIME_LO);
  assign w_wr_hi     = bus.write_en && (w_sel == A_MTIME_HI);
  assign w_wr_cmp_lo = bus.write_en && (w_sel == A_CMP_LO);
  assign w_wr_cmp_hi = bus.write_en && (w_sel == A_CMP_HI);
  assign w_wr_ctrl   = bus.write_en && (w_sel == A_CTRL);

  assign w_tick  = r_en && (r_cnt == r_div);
  assign w_match = (r_mtime >= r_mtimecmp);

  always_comb begin
    w_ctrl                 = '0;
    w_ctrl[8 +: PRESCALE_W] = r_div;
    w_ctrl[0]              = r_en;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_mtime    <= '0;
      r_mtimecmp <= CMP_RESET;
      r_en       <= 1'b0;
      r_div      <= '0;
      r_cnt      <= '0;
      r_snap     <= '0;
      r_addr_q   <= '0;
      r_intr     <= 1'b0;
    end else begin
      r_addr_q <= w_sel;
      r_intr   <= w_match & r_en;

      // LO read latches HI so a following HI read is coherent with it.
      if (bus.read_en && (w_sel == A_MTIME_LO))
        r_snap <= r_mtime[63:32];

      // A software write wins over a same-cycle tick; the tick is dropped.
      if (w_wr_lo)
        r_mtime[31:0] <= bus.data_in;
      else if (w_wr_hi)
        r_mtime[63:32] <= bus.data_in;
      else if (w_tick)
        r_mtime <= r_mtime + 64'd1;

      if (w_wr_cmp_lo) r_mtimecmp[31:0]  <= bus.data_in;
      if (w_wr_cmp_hi) r_mtimecmp[63:32] <= bus.data_in;

      if (w_wr_ctrl) begin
        r_en  <= bus.data_in[0];
        r_div <= bus.data_in[8 +: PRESCALE_W];
        r_cnt <= '0;
      end else if (!r_en || w_tick) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    bus.data_out = '0;
    case (r_addr_q)
      A_MTIME_LO: bus.data_out = r_mtime[31:0];
      A_MTIME_HI: bus.data_out = r_snap;
      A_CMP_LO:   bus.data_out = r_mtimecmp[31:0];
      A_CMP_HI:   bus.data_out = r_mtimecmp[63:32];
      A_CTRL:     bus.data_out = w_ctrl;
      A_STATUS:   bus.data_out = {31'b0, w_match};
      default:    bus.data_out = '0;
    endcase
  end

  assign o_intr_timer = r_intr;

endmodule

// File: tb/tb_mtimer.sv
// Directed bench for mtimer: register map, prescaler, snapshot coherence,
// write/tick priority, reset override and interrupt timing.
module tb_mtimer;
  logic clk = 1'b0;
  logic reset;
  logic intr;
  int   nchk = 0;
  int   nerr = 0;

  mtimer_if bus();

  mtimer dut (
    .i_clk        (clk),
    .i_reset      (reset),
    .bus          (bus.slave),
    .o_intr_timer (intr)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp)
    else begin
      nerr++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    bus.addr     = a;
    bus.data_in  = d;
    bus.write_en = 1'b1;
    step();
    bus.write_en = 1'b0;
  endtask

  task automatic rd(input logic [4:0] a, input logic [31:0] exp, input string tag);
    bus.addr    = a;
    bus.read_en = 1'b1;
    step();
    bus.read_en = 1'b0;
    chk(tag, bus.data_out, exp);
  endtask

  localparam logic [4:0] LO = 5'h00, HI = 5'h04, CLO = 5'h08, CHI = 5'h0C,
                         CTRL = 5'h10, STAT = 5'h14, R6 = 5'h18, R7 = 5'h1C;

  initial begin
    bus.addr = '0; bus.data_in = '0; bus.write_en = 1'b0; bus.read_en = 1'b0;
    reset = 1'b1;
    step(); step();
    chk("rst_dout_lo", bus.data_out, 32'h0);
    chk("rst_intr", {31'b0, intr}, 32'h0);
    reset = 1'b0;

    // 1: reset values of all registers
    rd(LO,   32'h0,        "t1_lo");
    rd(HI,   32'h0,        "t1_hi");
    rd(CLO,  32'hFFFFFFFF, "t1_cmp_lo");
    rd(CHI,  32'hFFFFFFFF, "t1_cmp_hi");
    rd(CTRL, 32'h0,        "t1_ctrl");
    rd(STAT, 32'h0,        "t1_status");
    rd(R6,   32'h0,        "t1_r6");
    rd(R7,   32'h0,        "t1_r7");
    chk("t1_intr", {31'b0, intr}, 32'h0);

    // 2: div 0, compare at 10; intr one cycle after match
    wr(CHI, 32'h0);
    wr(CLO, 32'd10);
    wr(CTRL, 32'h001);
    bus.addr = STAT;
    repeat (9) step();
    chk("t2_status_m9", bus.data_out, 32'h0);
    chk("t2_intr_m9", {31'b0, intr}, 32'h0);
    step();
    chk("t2_status_m10", bus.data_out, 32'h1);
    chk("t2_intr_m10", {31'b0, intr}, 32'h0);
    step();
    chk("t2_intr_m11", {31'b0, intr}, 32'h1);
    wr(CLO, 32'd20);
    chk("t2_intr_at_wr", {31'b0, intr}, 32'h1);
    step();
    chk("t2_intr_cleared", {31'b0, intr}, 32'h0);

    // 3: div 3 gives one tick per 4 cycles; en=0 freezes
    wr(CTRL, 32'h0);
    wr(LO, 32'h0);
    wr(HI, 32'h0);
    wr(CTRL, 32'h301);
    bus.addr = LO;
    repeat (3) step();
    chk("t3_lo_c3", bus.data_out, 32'd0);
    step();
    chk("t3_lo_c4", bus.data_out, 32'd1);
    repeat (3) step();
    chk("t3_lo_c7", bus.data_out, 32'd1);
    step();
    chk("t3_lo_c8", bus.data_out, 32'd2);
    wr(CTRL, 32'h0);
    bus.addr = LO;
    repeat (5) step();
    chk("t3_frozen", bus.data_out, 32'd2);
    rd(CTRL, 32'h0, "t3_ctrl_rb");

    // 4: carry into HI and snapshot coherence
    wr(LO, 32'hFFFFFFFF);
    wr(HI, 32'h0);
    wr(CTRL, 32'h001);
    wr(CTRL, 32'h000);
    rd(LO, 32'h0, "t4_lo_after_carry");
    rd(HI, 32'h1, "t4_hi_after_carry");
    wr(HI, 32'h7);
    rd(HI, 32'h1, "t4_hi_stale");
    rd(LO, 32'h0, "t4_lo_again");
    rd(HI, 32'h7, "t4_hi_fresh");

    // 5: write beats tick; reset beats write
    wr(CTRL, 32'h001);
    wr(LO, 32'd5);
    chk("t5_lo_write_wins", bus.data_out, 32'd5);
    wr(CTRL, 32'h000);
    rd(LO, 32'd6, "t5_lo_after_tick");
    bus.addr = LO; bus.data_in = 32'h55; bus.write_en = 1'b1; reset = 1'b1;
    step();
    bus.write_en = 1'b0; reset = 1'b0;
    chk("t5_rst_lo", bus.data_out, 32'h0);
    chk("t5_rst_intr", {31'b0, intr}, 32'h0);
    rd(HI,   32'h0,        "t5_rst_snap");
    rd(CLO,  32'hFFFFFFFF, "t5_rst_cmp_lo");
    rd(CTRL, 32'h0,        "t5_rst_ctrl");

    // 6: all-ones match, wrap clears it; STATUS ungated by en
    wr(LO, 32'hFFFFFFFF);
    wr(HI, 32'hFFFFFFFF);
    rd(STAT, 32'h1, "t6_status_en0");
    chk("t6_intr_en0", {31'b0, intr}, 32'h0);
    wr(CTRL, 32'h101);
    chk("t6_intr_k0", {31'b0, intr}, 32'h0);
    bus.addr = STAT;
    step();
    chk("t6_intr_k1", {31'b0, intr}, 32'h1);
    chk("t6_status_k1", bus.data_out, 32'h1);
    step();
    chk("t6_intr_k2", {31'b0, intr}, 32'h1);
    chk("t6_status_wrapped", bus.data_out, 32'h0);
    step();
    chk("t6_intr_k3", {31'b0, intr}, 32'h0);
    wr(CTRL, 32'h0);
    rd(LO, 32'd1, "t6_lo_frozen");
    wr(CHI, 32'h0);
    wr(CLO, 32'd1);
    rd(STAT, 32'h1, "t6_status_eq");
    chk("t6_intr_gated", {31'b0, intr}, 32'h0);
    wr(CLO, 32'd2);
    rd(STAT, 32'h0, "t6_status_below");

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
